// File: rtl/pt_frame_sched.sv
// Round-robin scheduler sharing one PT2262 encoder; each grant sends REPEAT frames then acks.
// Optional macro PT_SCHED_GAP_EN inserts GAP idle cycles between repeats.
module pt_frame_sched #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int REPEAT = 4,
  parameter int GAP    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   code,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 enc_ld,
  output logic [23:0]          enc_ad,
  input  logic                 enc_done
);

  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) || REPEAT < 1 || REPEAT > 15 ||
      GAP < 1 || GAP > 255) begin : g_bad_param
    $error("pt_frame_sched: parameter out of range");
  end

`ifdef PT_SCHED_GAP_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP, S_ACK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK} state_t;
`endif

  state_t            r_state;
  logic [3:0]        r_rep;
  logic [IDW-1:0]    r_last;
  logic [NREQ-1:0]   r_ack;
  logic              r_busy;
  logic [IDW-1:0]    r_gid;
  logic              r_ld;
  logic [23:0]       r_ad;
`ifdef PT_SCHED_GAP_EN
  logic [7:0]        r_gap;
`endif

  logic              w_any;
  logic [IDW-1:0]    w_pick;
  logic [23:0]       w_code;
  logic [NREQ-1:0]   w_onehot;

  // Rotating search starting just above the last served requester.
  always_comb begin : p_arb
    logic [IDW:0] v_idx;
    w_any  = 1'b0;
    w_pick = '0;
    v_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = {1'b0, r_last} + (IDW+1)'(k + 1);
      if (v_idx >= (IDW+1)'(NREQ)) begin
        v_idx = v_idx - (IDW+1)'(NREQ);
      end
      if (!w_any && req[v_idx[IDW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = v_idx[IDW-1:0];
      end
    end
  end

  assign w_code   = code[24*w_pick +: 24];
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_gid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rep   <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_gid   <= '0;
      r_ld    <= 1'b0;
      r_ad    <= '0;
`ifdef PT_SCHED_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_ld  <= 1'b0;
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gid   <= w_pick;
            r_ad    <= w_code;
            r_rep   <= '0;
            r_busy  <= 1'b1;
            r_ld    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done seen in any other state belongs to a frame we no longer own.
          if (enc_done) begin
            if (r_rep == 4'(REPEAT - 1)) begin
              r_ack   <= w_onehot;
              r_state <= S_ACK;
            end else begin
              r_rep   <= r_rep + 4'd1;
`ifdef PT_SCHED_GAP_EN
              r_gap   <= 8'(GAP - 1);
              r_state <= S_GAP;
`else
              r_ld    <= 1'b1;
              r_state <= S_LOAD;
`endif
            end
          end
        end
`ifdef PT_SCHED_GAP_EN
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_ld    <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
`endif
        S_ACK: begin
          r_busy  <= 1'b0;
          r_last  <= r_gid;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign busy     = r_busy;
  assign grant_id = r_gid;
  assign enc_ld   = r_ld;
  assign enc_ad   = r_ad;

  a_ld_single: assert property (@(posedge clk) disable iff (!rst_n) r_ld |=> !r_ld);
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ack));

endmodule

// File: tb/tb_pt_frame_sched.sv
// Randomized bench for pt_frame_sched against a transaction-level round-robin model.
module tb_pt_frame_sched;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int REPEAT = 4;
  localparam int GAP    = 16;
`ifdef PT_SCHED_GAP_EN
  localparam int SPACING = GAP + 1;
`else
  localparam int SPACING = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [24*NREQ-1:0] code = '0;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic               enc_ld;
  logic [23:0]        enc_ad;
  logic               enc_done;
  logic               model_done = 1'b0;
  logic               spur_done = 1'b0;
  assign enc_done = model_done | spur_done;

  logic [1:0]  req1 = '0;
  logic [47:0] code1 = '0;
  logic [1:0]  ack1;
  logic        busy1;
  logic [0:0]  gid1;
  logic        ld1;
  logic [23:0] ad1;
  logic        done1 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int last_grant = NREQ - 1;
  int enc_lat = 10;
  int enc_cnt = 0;
  int enc1_cnt = 0;

  pt_frame_sched #(.NREQ(NREQ), .IDW(IDW), .REPEAT(REPEAT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code), .ack(ack), .busy(busy),
    .grant_id(grant_id), .enc_ld(enc_ld), .enc_ad(enc_ad), .enc_done(enc_done)
  );

  pt_frame_sched #(.NREQ(2), .IDW(1), .REPEAT(1), .GAP(GAP)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .code(code1), .ack(ack1), .busy(busy1),
    .grant_id(gid1), .enc_ld(ld1), .enc_ad(ad1), .enc_done(done1)
  );

  // Encoder models: done pulses enc_lat cycles after the ld cycle.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      enc_cnt = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0) model_done = 1'b1;
      end
      if (enc_ld) enc_cnt = enc_lat;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      enc1_cnt = 0;
      done1 = 1'b0;
    end else begin
      done1 = 1'b0;
      if (enc1_cnt > 0) begin
        enc1_cnt--;
        if (enc1_cnt == 0) done1 = 1'b1;
      end
      if (ld1) enc1_cnt = 5;
    end
  end

  function automatic int predict(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Follows one whole service: grant, REPEAT frames, ack; requester drops req on its ack.
  task automatic serve_one(input int id, input logic [23:0] c, input bit spur_load,
                           output int wait_cyc);
    int n;
    logic [NREQ-1:0] exp_ack;
    exp_ack = '0;
    exp_ack[id] = 1'b1;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (enc_ld !== 1'b1 && wait_cyc < 300);
    vectors++;
    if (enc_ld !== 1'b1) begin
      $display("FAIL grant_timeout: enc_ld=%b after %0d cycles, required 1", enc_ld, wait_cyc);
      miscompares++;
      return;
    end
    vectors++;
    if (grant_id !== IDW'(id)) begin
      $display("FAIL grant_id: got %0d required %0d", grant_id, id);
      miscompares++;
    end
    code[id*24 +: 24] = 24'($urandom);
    for (int f = 0; f < REPEAT; f++) begin
      vectors++;
      if (enc_ad !== c) begin
        $display("FAIL enc_ad frame %0d: got %h required %h", f, enc_ad, c);
        miscompares++;
      end
      vectors++;
      if (busy !== 1'b1) begin
        $display("FAIL busy_load frame %0d: got %b required 1", f, busy);
        miscompares++;
      end
      spur_done = spur_load;
      n = 0;
      do begin
        @(negedge clk);
        spur_done = 1'b0;
        n++;
        vectors++;
        if (enc_ld !== 1'b0 || ack !== '0) begin
          $display("FAIL wait_quiet frame %0d: enc_ld=%b ack=%b required 0/0", f, enc_ld, ack);
          miscompares++;
        end
      end while (model_done !== 1'b1 && n < 200);
      if (model_done !== 1'b1) begin
        $display("FAIL done_timeout frame %0d: no done after %0d cycles", f, n);
        miscompares++;
        return;
      end
      if (f < REPEAT - 1) begin
        for (int g = 1; g < SPACING; g++) begin
          @(negedge clk);
          vectors++;
          if (enc_ld !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL gap cycle %0d: enc_ld=%b busy=%b required 0/1", g, enc_ld, busy);
            miscompares++;
          end
        end
        @(negedge clk);
        vectors++;
        if (enc_ld !== 1'b1) begin
          $display("FAIL ld_after_done frame %0d: enc_ld=%b required 1", f + 1, enc_ld);
          miscompares++;
          return;
        end
      end else begin
        @(negedge clk);
        vectors++;
        if (ack !== exp_ack || enc_ld !== 1'b0) begin
          $display("FAIL ack: got ack=%b enc_ld=%b required %b/0", ack, enc_ld, exp_ack);
          miscompares++;
        end
        req[id] = 1'b0;
        @(negedge clk);
        vectors++;
        if (ack !== '0 || busy !== 1'b0) begin
          $display("FAIL ack_end: ack=%b busy=%b required 0/0", ack, busy);
          miscompares++;
        end
      end
    end
    last_grant = id;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = NREQ - 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ack !== '0 || busy !== 1'b0 || grant_id !== '0 || enc_ld !== 1'b0 || enc_ad !== '0) begin
      $display("FAIL reset_values: ack=%b busy=%b gid=%0d ld=%b ad=%h required all 0",
               ack, busy, grant_id, enc_ld, enc_ad);
      miscompares++;
    end
    rst_n = 1'b1;
    last_grant = NREQ - 1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
      miscompares++;
    end
  endtask

  task automatic test_single();
    int w;
    enc_lat = 50;
    code[2*24 +: 24] = 24'hAAAA01;
    req[2] = 1'b1;
    serve_one(predict(req, last_grant), 24'hAAAA01, 1'b0, w);
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || enc_ld !== 1'b0) begin
      $display("FAIL single_tail: busy=%b enc_ld=%b required 0/0", busy, enc_ld);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    int w;
    int e;
    do_reset();
    for (int i = 0; i < NREQ; i++) code[i*24 +: 24] = 24'($urandom);
    req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      enc_lat = $urandom_range(3, 8);
      e = predict(req, last_grant);
      serve_one(e, code[e*24 +: 24], 1'b0, w);
      vectors++;
      if (w !== 1) begin
        $display("FAIL rr_latency service %0d: ld after %0d cycles, required 1", i, w);
        miscompares++;
      end
      if (i == 1) begin
        req[0] = 1'b1;
        code[0 +: 24] = 24'($urandom);
      end
    end
  endtask

  task automatic test_spurious();
    int w;
    int e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      vectors++;
      if (busy !== 1'b0 || enc_ld !== 1'b0) begin
        $display("FAIL spur_idle: busy=%b enc_ld=%b required 0/0", busy, enc_ld);
        miscompares++;
      end
    end
    enc_lat = 6;
    code[1*24 +: 24] = 24'($urandom);
    req[1] = 1'b1;
    e = predict(req, last_grant);
    serve_one(e, code[e*24 +: 24], 1'b1, w);
  endtask

  task automatic test_reset_mid();
    int w;
    int n;
    int lds;
    int e;
    enc_lat = 10;
    code[1*24 +: 24] = 24'($urandom);
    code[3*24 +: 24] = 24'($urandom);
    req = 4'b1010;
    lds = 0;
    n = 0;
    while (lds < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (enc_ld === 1'b1) lds++;
    end
    vectors++;
    if (lds != 2) begin
      $display("FAIL mid_setup: saw %0d loads, required 2", lds);
      miscompares++;
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (ack !== '0 || busy !== 1'b0 || grant_id !== '0 || enc_ld !== 1'b0 || enc_ad !== '0) begin
      $display("FAIL async_reset: ack=%b busy=%b gid=%0d ld=%b ad=%h required all 0",
               ack, busy, grant_id, enc_ld, enc_ad);
      miscompares++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = NREQ - 1;
    for (int i = 0; i < 2; i++) begin
      e = predict(req, last_grant);
      serve_one(e, code[e*24 +: 24], 1'b0, w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int e;
    for (int s = 0; s < 12; s++) begin
      if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) code[i*24 +: 24] = 24'($urandom);
      enc_lat = $urandom_range(2, 9);
      e = predict(req, last_grant);
      serve_one(e, code[e*24 +: 24], 1'b0, w);
      vectors++;
      if (w !== 1) begin
        $display("FAIL b2b_latency service %0d: ld after %0d cycles, required 1", s, w);
        miscompares++;
      end
      if ($urandom_range(0, 1) == 1) req = req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
    end
    req = '0;
  endtask

  task automatic test_repeat1();
    int last1;
    int e;
    int n;
    logic [1:0]  exp_ack;
    logic [23:0] c;
    last1 = 1;
    code1 = {24'($urandom), 24'($urandom)};
    req1 = 2'b11;
    for (int s = 0; s < 2; s++) begin
      e = req1[(last1 + 1) % 2] ? (last1 + 1) % 2 : last1;
      c = code1[e*24 +: 24];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ld1 !== 1'b1 && n < 50);
      vectors++;
      if (ld1 !== 1'b1 || gid1 !== 1'(e) || ad1 !== c) begin
        $display("FAIL r1_load: ld=%b gid=%0d ad=%h required 1/%0d/%h", ld1, gid1, ad1, e, c);
        miscompares++;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
        vectors++;
        if (ld1 !== 1'b0 || ack1 !== 2'b00) begin
          $display("FAIL r1_wait: ld=%b ack=%b required 0/00", ld1, ack1);
          miscompares++;
        end
      end while (done1 !== 1'b1 && n < 50);
      exp_ack = 2'b00;
      exp_ack[e] = 1'b1;
      @(negedge clk);
      vectors++;
      if (ack1 !== exp_ack || ld1 !== 1'b0) begin
        $display("FAIL r1_ack: ack=%b ld=%b required %b/0", ack1, ld1, exp_ack);
        miscompares++;
      end
      req1[e] = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b0 || ack1 !== 2'b00) begin
        $display("FAIL r1_idle: busy=%b ack=%b required 0/00", busy1, ack1);
        miscompares++;
      end
      last1 = e;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_repeat1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
